rs_age_select: RTL and testbench

Parametrised reservation station for the out-of-order RISC-V32 core, successor to the single-ALU station. It buffers decoded ALU operations with their operand tags and snoops N_CDB common-data-bus channels for wakeup. It issues the oldest ready entry to a downstream execution unit through a valid/ready handshake, and supports a pipeline flush. It sits between dispatch and the scalar ALU; its results return to the core on one of the CDB channels.

---
 rtl/rs_age_select.sv | 219 +++++++++++++++++++++
 tb/tb_rs_age_select.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rs_age_select.sv
// Reservation station with CDB wakeup and oldest-ready selection through an age matrix.
// older_q[j][i] set means entry j was inserted before entry i.
module rs_age_select #(
   parameter int RS_SIZE_BIT   = 3,
   parameter int ROB_WIDTH_BIT = 4,
   parameter int TYPE_BIT      = 4,
   parameter int N_CDB         = 2
) (
   input  logic                            clk_in,
   input  logic                            rst_n_in,
   input  logic                            rdy_in,
   input  logic                            flush,
   input  logic                            inst_valid,
   input  logic [TYPE_BIT-1:0]             inst_type,
   input  logic [ROB_WIDTH_BIT-1:0]        inst_rob_id,
   input  logic [31:0]                     inst_r1,
   input  logic [31:0]                     inst_r2,
   input  logic [ROB_WIDTH_BIT-1:0]        inst_dep1,
   input  logic [ROB_WIDTH_BIT-1:0]        inst_dep2,
   input  logic                            inst_has_dep1,
   input  logic                            inst_has_dep2,
   input  logic [N_CDB-1:0]                cdb_valid,
   input  logic [N_CDB*ROB_WIDTH_BIT-1:0]  cdb_rob_id,
   input  logic [N_CDB*32-1:0]             cdb_value,
   output logic                            issue_valid,
   input  logic                            issue_ready,
   output logic [TYPE_BIT-1:0]             issue_type,
   output logic [ROB_WIDTH_BIT-1:0]        issue_rob_id,
   output logic [31:0]                     issue_r1,
   output logic [31:0]                     issue_r2,
   output logic                            full,
   output logic [RS_SIZE_BIT:0]            count
);

   localparam int RS_SIZE = 1 << RS_SIZE_BIT;
   localparam logic [RS_SIZE_BIT:0] FULL_CNT = (RS_SIZE_BIT+1)'(RS_SIZE);

   logic [RS_SIZE-1:0]       busy_q, busy_d, hd1_q, hd1_d, hd2_q, hd2_d;
   logic [RS_SIZE-1:0]       older_q [RS_SIZE];
   logic [RS_SIZE-1:0]       older_d [RS_SIZE];
   logic [TYPE_BIT-1:0]      type_q  [RS_SIZE];
   logic [TYPE_BIT-1:0]      type_d  [RS_SIZE];
   logic [ROB_WIDTH_BIT-1:0] rob_q   [RS_SIZE];
   logic [ROB_WIDTH_BIT-1:0] rob_d   [RS_SIZE];
   logic [ROB_WIDTH_BIT-1:0] dep1_q  [RS_SIZE];
   logic [ROB_WIDTH_BIT-1:0] dep1_d  [RS_SIZE];
   logic [ROB_WIDTH_BIT-1:0] dep2_q  [RS_SIZE];
   logic [ROB_WIDTH_BIT-1:0] dep2_d  [RS_SIZE];
   logic [31:0]              r1_q    [RS_SIZE];
   logic [31:0]              r1_d    [RS_SIZE];
   logic [31:0]              r2_q    [RS_SIZE];
   logic [31:0]              r2_d    [RS_SIZE];
   logic [RS_SIZE_BIT:0]     count_q, count_d;
   logic                     full_q, full_d;

   logic [RS_SIZE-1:0]       ready_s;
   logic                     sel_found_s, blocked_s, free_found_s;
   logic [RS_SIZE_BIT-1:0]   sel_idx_s, free_idx_s;
   logic                     ins_fire_s, iss_fire_s;
   logic [32:0]              m1_s, m2_s;

   // Returns {hit, value}; the loop runs downward so the lowest matching channel wins.
   function automatic logic [32:0] cdb_lookup(input logic [ROB_WIDTH_BIT-1:0] tag,
                                              input logic [N_CDB-1:0] v,
                                              input logic [N_CDB*ROB_WIDTH_BIT-1:0] ids,
                                              input logic [N_CDB*32-1:0] vals);
      logic [32:0] r;
      r = 33'd0;
      for (int k = N_CDB - 1; k >= 0; k--) begin
         if (v[k] && (ids[k*ROB_WIDTH_BIT +: ROB_WIDTH_BIT] == tag)) begin
            r = {1'b1, vals[k*32 +: 32]};
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   // Oldest-ready selection, lowest free slot, and the combinational issue port.
   always_comb begin
      ready_s      = busy_q & ~hd1_q & ~hd2_q;
      sel_found_s  = 1'b0;
      sel_idx_s    = '0;
      free_found_s = 1'b0;
      free_idx_s   = '0;
      blocked_s    = 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
         blocked_s = 1'b0;
         for (int j = 0; j < RS_SIZE; j++) begin
            blocked_s = blocked_s | (ready_s[j] & older_q[j][i]);
         end
         if (ready_s[i] && !blocked_s && !sel_found_s) begin
            sel_found_s = 1'b1;
            sel_idx_s   = RS_SIZE_BIT'(i);
         end else begin
            sel_found_s = sel_found_s;
         end
         if (!busy_q[i] && !free_found_s) begin
            free_found_s = 1'b1;
            free_idx_s   = RS_SIZE_BIT'(i);
         end else begin
            free_found_s = free_found_s;
         end
      end
      issue_valid = rdy_in & sel_found_s;
      if (sel_found_s) begin
         issue_type   = type_q[sel_idx_s];
         issue_rob_id = rob_q[sel_idx_s];
         issue_r1     = r1_q[sel_idx_s];
         issue_r2     = r2_q[sel_idx_s];
      end else begin
         issue_type   = '0;
         issue_rob_id = '0;
         issue_r1     = 32'd0;
         issue_r2     = 32'd0;
      end
   end

   // Next-state: flush beats insert and issue; wakeup, free and insert otherwise.
   always_comb begin
      busy_d  = busy_q;  hd1_d  = hd1_q;  hd2_d  = hd2_q;  older_d = older_q;
      type_d  = type_q;  rob_d  = rob_q;  dep1_d = dep1_q; dep2_d  = dep2_q;
      r1_d    = r1_q;    r2_d   = r2_q;   count_d = count_q; full_d = full_q;
      m1_s    = 33'd0;   m2_s   = 33'd0;
      ins_fire_s = inst_valid & ~full_q & ~flush & rdy_in & free_found_s;
      iss_fire_s = issue_valid & issue_ready & ~flush;
      if (!rdy_in) begin
         busy_d = busy_q;
      end else if (flush) begin
         busy_d  = '0;
         count_d = '0;
         full_d  = 1'b0;
      end else begin
         for (int i = 0; i < RS_SIZE; i++) begin
            m1_s = cdb_lookup(dep1_q[i], cdb_valid, cdb_rob_id, cdb_value);
            m2_s = cdb_lookup(dep2_q[i], cdb_valid, cdb_rob_id, cdb_value);
            if (busy_q[i] && hd1_q[i] && m1_s[32]) begin
               r1_d[i]  = m1_s[31:0];
               hd1_d[i] = 1'b0;
            end else begin
               hd1_d[i] = hd1_q[i];
            end
            if (busy_q[i] && hd2_q[i] && m2_s[32]) begin
               r2_d[i]  = m2_s[31:0];
               hd2_d[i] = 1'b0;
            end else begin
               hd2_d[i] = hd2_q[i];
            end
         end
         if (iss_fire_s) begin
            busy_d[sel_idx_s] = 1'b0;
         end else begin
            busy_d[sel_idx_s] = busy_q[sel_idx_s];
         end
         if (ins_fire_s) begin
            m1_s = cdb_lookup(inst_dep1, cdb_valid, cdb_rob_id, cdb_value);
            m2_s = cdb_lookup(inst_dep2, cdb_valid, cdb_rob_id, cdb_value);
            busy_d[free_idx_s] = 1'b1;
            type_d[free_idx_s] = inst_type;
            rob_d[free_idx_s]  = inst_rob_id;
            dep1_d[free_idx_s] = inst_dep1;
            dep2_d[free_idx_s] = inst_dep2;
            r1_d[free_idx_s]   = (inst_has_dep1 && m1_s[32]) ? m1_s[31:0] : inst_r1;
            r2_d[free_idx_s]   = (inst_has_dep2 && m2_s[32]) ? m2_s[31:0] : inst_r2;
            hd1_d[free_idx_s]  = inst_has_dep1 & ~m1_s[32];
            hd2_d[free_idx_s]  = inst_has_dep2 & ~m2_s[32];
            older_d[free_idx_s] = '0;
            for (int j = 0; j < RS_SIZE; j++) begin
               older_d[j][free_idx_s] = busy_q[j];
            end
         end else begin
            busy_d[free_idx_s] = busy_d[free_idx_s];
         end
         case ({ins_fire_s, iss_fire_s})
            2'b10:   count_d = count_q + {{RS_SIZE_BIT{1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{RS_SIZE_BIT{1'b0}}, 1'b1};
            default: count_d = count_q;
         endcase
         full_d = (count_d == FULL_CNT);
      end
   end

   // State registers; reset discards every entry immediately.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         busy_q  <= '0;
         hd1_q   <= '0;
         hd2_q   <= '0;
         count_q <= '0;
         full_q  <= 1'b0;
         for (int i = 0; i < RS_SIZE; i++) begin
            older_q[i] <= '0;
            type_q[i]  <= '0;
            rob_q[i]   <= '0;
            dep1_q[i]  <= '0;
            dep2_q[i]  <= '0;
            r1_q[i]    <= 32'd0;
            r2_q[i]    <= 32'd0;
         end
      end else begin
         busy_q  <= busy_d;
         hd1_q   <= hd1_d;
         hd2_q   <= hd2_d;
         count_q <= count_d;
         full_q  <= full_d;
         older_q <= older_d;
         type_q  <= type_d;
         rob_q   <= rob_d;
         dep1_q  <= dep1_d;
         dep2_q  <= dep2_d;
         r1_q    <= r1_d;
         r2_q    <= r2_d;
      end
   end

   assign count = count_q;
   assign full  = full_q;

endmodule

// File: tb/tb_rs_age_select.sv
// Directed bench for rs_age_select: fill/overflow, age order, CDB wakeup, flush and async reset.
module tb_rs_age_select;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        rdy_in = 1'b1;
   logic        flush = 1'b0;
   logic        inst_valid = 1'b0;
   logic [3:0]  inst_type = 4'd0;
   logic [3:0]  inst_rob_id = 4'd0;
   logic [31:0] inst_r1 = 32'd0, inst_r2 = 32'd0;
   logic [3:0]  inst_dep1 = 4'd0, inst_dep2 = 4'd0;
   logic        inst_has_dep1 = 1'b0, inst_has_dep2 = 1'b0;
   logic [1:0]  cdb_valid = 2'b00;
   logic [7:0]  cdb_rob_id = 8'd0;
   logic [63:0] cdb_value = 64'd0;
   logic        issue_ready = 1'b0;
   logic        issue_valid, full;
   logic [3:0]  issue_type, issue_rob_id, count;
   logic [31:0] issue_r1, issue_r2;

   int checks = 0;
   int errors = 0;

   rs_age_select dut (
      .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .flush(flush),
      .inst_valid(inst_valid), .inst_type(inst_type), .inst_rob_id(inst_rob_id),
      .inst_r1(inst_r1), .inst_r2(inst_r2), .inst_dep1(inst_dep1), .inst_dep2(inst_dep2),
      .inst_has_dep1(inst_has_dep1), .inst_has_dep2(inst_has_dep2),
      .cdb_valid(cdb_valid), .cdb_rob_id(cdb_rob_id), .cdb_value(cdb_value),
      .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_type(issue_type),
      .issue_rob_id(issue_rob_id), .issue_r1(issue_r1), .issue_r2(issue_r2),
      .full(full), .count(count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ins(input logic [3:0] rob, input logic [31:0] a, input logic [31:0] b,
                      input logic hd1, input logic [3:0] d1, input logic hd2, input logic [3:0] d2);
      inst_valid = 1'b1; inst_rob_id = rob; inst_type = rob;
      inst_r1 = a; inst_r2 = b;
      inst_has_dep1 = hd1; inst_dep1 = d1; inst_has_dep2 = hd2; inst_dep2 = d2;
   endtask

   initial begin
      // reset state
      #2;
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_full", 32'(full), 32'd0);
      chk("rst_issue_valid", 32'(issue_valid), 32'd0);
      chk("rst_issue_r1", issue_r1, 32'd0);
      #10 rst_n = 1'b1;
      tick();

      // fill all 8 entries, then an ignored 9th dispatch
      for (int i = 0; i < 8; i++) begin
         ins(4'(i), 32'(i) + 32'h100, 32'(i) + 32'h200, 1'b0, 4'd0, 1'b0, 4'd0);
         tick();
      end
      inst_valid = 1'b0;
      chk("fill_count", 32'(count), 32'd8);
      chk("fill_full", 32'(full), 32'd1);
      chk("fill_oldest", 32'(issue_rob_id), 32'd0);
      ins(4'd15, 32'hffff, 32'hffff, 1'b0, 4'd0, 1'b0, 4'd0);
      tick();
      inst_valid = 1'b0;
      chk("overflow_count", 32'(count), 32'd8);
      issue_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         chk("drain_rob", 32'(issue_rob_id), 32'(i));
         chk("drain_r1", issue_r1, 32'(i) + 32'h100);
         tick();
      end
      chk("drain_count", 32'(count), 32'd0);
      chk("drain_valid", 32'(issue_valid), 32'd0);

      // A then B, then Z reuses A's slot 0 but is younger than B
      issue_ready = 1'b0;
      ins(4'd3, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      ins(4'd5, 32'd3, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      inst_valid = 1'b0; issue_ready = 1'b1; #1;
      chk("age_A", 32'(issue_rob_id), 32'd3);
      tick();
      issue_ready = 1'b0;
      ins(4'd6, 32'd5, 32'd6, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      inst_valid = 1'b0; issue_ready = 1'b1; #1;
      chk("age_B", 32'(issue_rob_id), 32'd5);
      tick();
      chk("age_Z", 32'(issue_rob_id), 32'd6);
      tick();
      chk("age_count", 32'(count), 32'd0);

      // C waits on rob 7, broadcast on channel 1 two cycles later
      issue_ready = 1'b0;
      ins(4'd1, 32'd0, 32'h55, 1'b1, 4'd7, 1'b0, 4'd0); tick();
      inst_valid = 1'b0;
      chk("C_wait", 32'(issue_valid), 32'd0);
      tick();
      cdb_valid = 2'b10; cdb_rob_id = {4'd7, 4'd0}; cdb_value = {32'h1234, 32'h0}; #1;
      chk("C_no_bypass", 32'(issue_valid), 32'd0);
      tick();
      cdb_valid = 2'b00; #1;
      chk("C_valid", 32'(issue_valid), 32'd1);
      chk("C_r1", issue_r1, 32'h1234);
      chk("C_r2", issue_r2, 32'h55);
      issue_ready = 1'b1; tick(); issue_ready = 1'b0;

      // D inserted while both channels broadcast rob 9; channel 0 wins
      ins(4'd2, 32'h11, 32'd0, 1'b0, 4'd0, 1'b1, 4'd9);
      cdb_valid = 2'b11; cdb_rob_id = {4'd9, 4'd9}; cdb_value = {32'hbeef, 32'hdead};
      tick();
      inst_valid = 1'b0; cdb_valid = 2'b00; #1;
      chk("D_valid", 32'(issue_valid), 32'd1);
      chk("D_r2", issue_r2, 32'hdead);
      chk("D_r1", issue_r1, 32'h11);
      issue_ready = 1'b1; tick(); issue_ready = 1'b0;
      chk("D_count", 32'(count), 32'd0);

      // flush with 4 entries (2 ready) plus simultaneous insert and issue
      ins(4'd1, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      ins(4'd2, 32'd2, 32'd2, 1'b1, 4'd12, 1'b0, 4'd0); tick();
      ins(4'd3, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      ins(4'd4, 32'd4, 32'd4, 1'b0, 4'd0, 1'b1, 4'd13); tick();
      chk("pre_flush_count", 32'(count), 32'd4);
      ins(4'd8, 32'd8, 32'd8, 1'b0, 4'd0, 1'b0, 4'd0);
      flush = 1'b1; issue_ready = 1'b1;
      tick();
      flush = 1'b0; inst_valid = 1'b0; issue_ready = 1'b0; #1;
      chk("flush_count", 32'(count), 32'd0);
      chk("flush_full", 32'(full), 32'd0);
      chk("flush_valid", 32'(issue_valid), 32'd0);
      cdb_valid = 2'b01; cdb_rob_id = {4'd0, 4'd12}; cdb_value = 64'd7;
      tick();
      cdb_valid = 2'b00; #1;
      chk("flush_no_wake", 32'(issue_valid), 32'd0);

      // 5 busy entries, rdy_in pause, then async reset between edges
      for (int i = 0; i < 5; i++) begin
         ins(4'(i + 1), 32'(i), 32'(i), 1'b0, 4'd0, 1'b0, 4'd0);
         tick();
      end
      chk("five_count", 32'(count), 32'd5);
      rdy_in = 1'b0; issue_ready = 1'b1;
      ins(4'd9, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0); #1;
      chk("pause_valid", 32'(issue_valid), 32'd0);
      tick();
      chk("pause_count", 32'(count), 32'd5);
      rdy_in = 1'b1; inst_valid = 1'b0; issue_ready = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      chk("async_count", 32'(count), 32'd0);
      chk("async_valid", 32'(issue_valid), 32'd0);
      chk("async_rob", 32'(issue_rob_id), 32'd0);
      chk("async_r1", issue_r1, 32'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("post_rst_count", 32'(count), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
